// File: rtl/fpu_op_sched_if.sv
// Request, shared-operand and response signals of the FPU issue scheduler.
// The scheduler takes the slave modport; requester plus core cluster take master.
interface fpu_op_sched_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      fpu_dataa;
  logic [31:0]      fpu_datab;
  logic [31:0]      fpu_res_add;
  logic [31:0]      fpu_res_sub;
  logic [31:0]      fpu_res_mul;
  logic [31:0]      fpu_res_div;
  logic             rsp_valid;
  logic [1:0]       rsp_op;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;
  logic             busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag,
    input  fpu_res_add, fpu_res_sub, fpu_res_mul, fpu_res_div,
    output req_ready, fpu_dataa, fpu_datab,
    output rsp_valid, rsp_op, rsp_tag, rsp_data, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag,
    output fpu_res_add, fpu_res_sub, fpu_res_mul, fpu_res_div,
    input  req_ready, fpu_dataa, fpu_datab,
    input  rsp_valid, rsp_op, rsp_tag, rsp_data, busy
  );
endinterface

// File: rtl/fpu_op_sched.sv
// Issue scheduler for the shared add/sub/mul/div cores with a completion-slot reservation vector.
// Optional macro FPU_SCHED_INORDER_EN: responses return strictly in issue order.
module fpu_op_sched #(
  parameter int LAT_ADD = 7,
  parameter int LAT_SUB = 7,
  parameter int LAT_MUL = 5,
  parameter int LAT_DIV = 6,
  parameter int MAX_LAT = 16,
  parameter int TAG_W   = 4
) (
  input logic           clk,
  input logic           rst,
  fpu_op_sched_if.slave bus
);
  localparam int LW = $clog2(MAX_LAT + 1);

  if (LAT_ADD < 1 || LAT_ADD > MAX_LAT || LAT_SUB < 1 || LAT_SUB > MAX_LAT ||
      LAT_MUL < 1 || LAT_MUL > MAX_LAT || LAT_DIV < 1 || LAT_DIV > MAX_LAT) begin : g_lat_check
    $error("fpu_op_sched: every LAT_* must lie in 1..MAX_LAT");
  end

  // Index 0 is the slot whose core result is captured on the coming edge.
  logic [MAX_LAT:0] res_q, res_d, res_sh;
  logic [1:0]       op_q  [MAX_LAT:0];
  logic [1:0]       op_d  [MAX_LAT:0];
  logic [TAG_W-1:0] tag_q [MAX_LAT:0];
  logic [TAG_W-1:0] tag_d [MAX_LAT:0];
  logic [31:0]      dataa_q, dataa_d, datab_q, datab_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_op_q, rsp_op_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [LW-1:0]    lat;
  logic             slot_free, order_ok, ready, accept;
  logic [31:0]      core_res;

  always_comb begin
    case (bus.req_op)
      2'd0:    lat = LW'(LAT_ADD);
      2'd1:    lat = LW'(LAT_SUB);
      2'd2:    lat = LW'(LAT_MUL);
      default: lat = LW'(LAT_DIV);
    endcase
  end

  // Conflicts are judged against the post-shift vector, where a new entry is written.
  assign res_sh = {1'b0, res_q[MAX_LAT:1]};

  always_comb begin
    slot_free = ~res_sh[lat];
    order_ok  = 1'b1;
`ifdef FPU_SCHED_INORDER_EN
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (LW'(k) >= lat && res_sh[k]) order_ok = 1'b0;
    end
`else
    order_ok  = 1'b1;
`endif
  end

  assign ready  = ~rst & slot_free & order_ok;
  assign accept = bus.req_valid & ready;

  always_comb begin
    case (op_q[0])
      2'd0:    core_res = bus.fpu_res_add;
      2'd1:    core_res = bus.fpu_res_sub;
      2'd2:    core_res = bus.fpu_res_mul;
      default: core_res = bus.fpu_res_div;
    endcase
  end

  always_comb begin
    res_d = res_sh;
    for (int k = 0; k < MAX_LAT; k++) begin
      op_d[k]  = op_q[k+1];
      tag_d[k] = tag_q[k+1];
    end
    op_d[MAX_LAT]  = '0;
    tag_d[MAX_LAT] = '0;
    dataa_d = dataa_q;
    datab_d = datab_q;
    if (accept) begin
      res_d[lat] = 1'b1;
      op_d[lat]  = bus.req_op;
      tag_d[lat] = bus.req_tag;
      dataa_d    = bus.req_a;
      datab_d    = bus.req_b;
    end
    rsp_valid_d = res_q[0];
    rsp_op_d    = rsp_op_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;
    if (res_q[0]) begin
      rsp_op_d   = op_q[0];
      rsp_tag_d  = tag_q[0];
      rsp_data_d = core_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      for (int k = 0; k <= MAX_LAT; k++) begin
        op_q[k]  <= '0;
        tag_q[k] <= '0;
      end
      dataa_q     <= '0;
      datab_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      res_q <= res_d;
      for (int k = 0; k <= MAX_LAT; k++) begin
        op_q[k]  <= op_d[k];
        tag_q[k] <= tag_d[k];
      end
      dataa_q     <= dataa_d;
      datab_q     <= datab_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.fpu_dataa = dataa_q;
  assign bus.fpu_datab = datab_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = |res_q;
endmodule

// File: tb/tb_fpu_op_sched.sv
// Bench for fpu_op_sched: fixed-latency core models, due-time reference model,
// vector table, hand-written corner sequences and randomized traffic.
module tb_fpu_op_sched;
  localparam int LA = 7, LS = 7, LM = 5, LD = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_op_sched_if #(.TAG_W(4)) bus ();
  fpu_op_sched #(.LAT_ADD(LA), .LAT_SUB(LS), .LAT_MUL(LM), .LAT_DIV(LD),
                 .MAX_LAT(16), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] last_a = '0, last_b = '0;

  function automatic real sp2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) return 0.0;
    d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] core_f(input logic [1:0] op, input logic [31:0] a, b);
    case (op)
      2'd0:    return r2sp(sp2r(a) + sp2r(b));
      2'd1:    return r2sp(sp2r(a) - sp2r(b));
      2'd2:    return r2sp(sp2r(a) * sp2r(b));
      default: return r2sp(sp2r(a) / sp2r(b));
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'd0:    return LA;
      2'd1:    return LS;
      2'd2:    return LM;
      default: return LD;
    endcase
  endfunction

  // Core cluster: result of the operands seen L cycles earlier.
  logic [31:0] ha [0:15];
  logic [31:0] hb [0:15];
  always @(posedge clk) begin
    ha[0] <= bus.fpu_dataa;
    hb[0] <= bus.fpu_datab;
    for (int i = 1; i < 16; i++) begin
      ha[i] <= ha[i-1];
      hb[i] <= hb[i-1];
    end
  end
  assign bus.fpu_res_add = core_f(2'd0, ha[LA-1], hb[LA-1]);
  assign bus.fpu_res_sub = core_f(2'd1, ha[LS-1], hb[LS-1]);
  assign bus.fpu_res_mul = core_f(2'd2, ha[LM-1], hb[LM-1]);
  assign bus.fpu_res_div = core_f(2'd3, ha[LD-1], hb[LD-1]);

  typedef struct {logic [1:0] op; logic [3:0] tag; logic [31:0] data; int due;} fl_t;
  fl_t inflight[$];
  fl_t rsp_log[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Ready rule in terms of due times: a new result may not land with, or (in-order) before, another.
  function automatic bit model_ready(input logic [1:0] op);
    int due;
    due = cyc + 1 + lat_of(op) + 1;
    foreach (inflight[i]) begin
      if (inflight[i].due == due) return 1'b0;
`ifdef FPU_SCHED_INORDER_EN
      if (inflight[i].due > due) return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

  task automatic step(input bit v, input logic [1:0] op, input logic [31:0] a, b,
                      input logic [3:0] tag, output bit rdy);
    bit exp_rdy, acc;
    int hit;
    fl_t e;
    bus.req_valid = v; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    #1;
    exp_rdy = model_ready(op);
    rdy = bus.req_ready;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (acc) begin
      e.op = op; e.tag = tag; e.data = core_f(op, a, b); e.due = cyc + 1 + lat_of(op) + 1;
      inflight.push_back(e);
      last_a = a; last_b = b;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("fpu_dataa", bus.fpu_dataa, last_a);
    chk("fpu_datab", bus.fpu_datab, last_b);
    hit = -1;
    foreach (inflight[i]) if (inflight[i].due == cyc) hit = i;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(hit >= 0));
    if (hit >= 0) begin
      chk("rsp_op",   32'(bus.rsp_op),  32'(inflight[hit].op));
      chk("rsp_tag",  32'(bus.rsp_tag), 32'(inflight[hit].tag));
      chk("rsp_data", bus.rsp_data, inflight[hit].data);
      inflight.delete(hit);
    end
    if (bus.rsp_valid) begin
      e.op = bus.rsp_op; e.tag = bus.rsp_tag; e.data = bus.rsp_data; e.due = cyc;
      rsp_log.push_back(e);
    end
    chk("busy", 32'(bus.busy), 32'(inflight.size() != 0));
  endtask

  task automatic idle(input int n);
    bit r;
    for (int i = 0; i < n; i++) step(1'b0, 2'(i), 32'd0, 32'd0, 4'd0, r);
  endtask

  task automatic chk_reset_outputs(input string tag_s);
    chk({tag_s, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag_s, "_rsp_op"},    32'(bus.rsp_op),    32'd0);
    chk({tag_s, "_rsp_tag"},   32'(bus.rsp_tag),   32'd0);
    chk({tag_s, "_rsp_data"},  bus.rsp_data,       32'd0);
    chk({tag_s, "_dataa"},     bus.fpu_dataa,      32'd0);
    chk({tag_s, "_datab"},     bus.fpu_datab,      32'd0);
    chk({tag_s, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag_s, "_ready"},     32'(bus.req_ready), 32'd0);
  endtask

  typedef struct {
    logic [1:0] op; logic [31:0] a, b; logic [3:0] tag; logic [31:0] exp_data; int exp_lat;
  } vec_t;

  initial begin
    vec_t vecs[4];
    bit r;
    int e0, tries;
    vecs[0] = '{2'd0, 32'h3F800000, 32'h40000000, 4'd3, 32'h40400000, 8};
    vecs[1] = '{2'd1, 32'h40A00000, 32'h40000000, 4'd5, 32'h40400000, LS + 1};
    vecs[2] = '{2'd2, 32'h40C00000, 32'h3F000000, 4'd9, 32'h40400000, 6};
    vecs[3] = '{2'd3, 32'h3F800000, 32'h40800000, 4'd12, 32'h3E800000, 7};

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.req_valid = 1'b1;
    #1;
    chk_reset_outputs("reset");
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single operations from the table
    foreach (vecs[i]) begin
      rsp_log.delete();
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, r);
      e0 = cyc;
      idle(12);
      chk("single_count", 32'(rsp_log.size()), 32'd1);
      if (rsp_log.size() == 1) begin
        chk("single_data", rsp_log[0].data, vecs[i].exp_data);
        chk("single_lat",  32'(rsp_log[0].due - e0), 32'(vecs[i].exp_lat));
        chk("single_tag",  32'(rsp_log[0].tag), 32'(vecs[i].tag));
        chk("single_op",   32'(rsp_log[0].op), 32'(vecs[i].op));
      end
    end

    // Slot collision: ADD at E0, MUL presented at E2 stalls one cycle
    rsp_log.delete();
    step(1'b1, 2'd0, 32'h3F800000, 32'h40000000, 4'd1, r);
    e0 = cyc;
    idle(1);
    step(1'b1, 2'd2, 32'h40C00000, 32'h3F000000, 4'd2, r);
    chk("collision_stall", 32'(r), 32'd0);
    step(1'b1, 2'd2, 32'h40C00000, 32'h3F000000, 4'd2, r);
    chk("collision_accept", 32'(r), 32'd1);
    idle(10);
    chk("collision_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() == 2) begin
      chk("collision_t0", 32'(rsp_log[0].due - e0), 32'd8);
      chk("collision_t1", 32'(rsp_log[1].due - e0), 32'd9);
    end

    // Reordering: ADD tag 1 then MUL tag 2 one cycle later
    rsp_log.delete();
    step(1'b1, 2'd0, 32'h40000000, 32'h40000000, 4'd1, r);
    e0 = cyc;
    tries = 0;
    r = 1'b0;
    while (!r && tries < 6) begin
      step(1'b1, 2'd2, 32'h40000000, 32'h40400000, 4'd2, r);
      tries++;
    end
    idle(10);
    chk("reorder_count", 32'(rsp_log.size()), 32'd2);
`ifdef FPU_SCHED_INORDER_EN
    chk("reorder_tries", 32'(tries), 32'd3);
    if (rsp_log.size() == 2) begin
      chk("reorder_first", 32'(rsp_log[0].tag), 32'd1);
      chk("reorder_second", 32'(rsp_log[1].tag), 32'd2);
    end
`else
    chk("reorder_tries", 32'(tries), 32'd1);
    if (rsp_log.size() == 2) begin
      chk("reorder_first", 32'(rsp_log[0].tag), 32'd2);
      chk("reorder_first_t", 32'(rsp_log[0].due - e0), 32'd7);
      chk("reorder_second", 32'(rsp_log[1].tag), 32'd1);
      chk("reorder_second_t", 32'(rsp_log[1].due - e0), 32'd8);
    end
`endif

    // Streaming 16 MULs
    rsp_log.delete();
    for (int t = 0; t < 16; t++) begin
      step(1'b1, 2'd2, r2sp(real'(t + 1)), 32'h40000000, 4'(t), r);
      chk("stream_ready", 32'(r), 32'd1);
    end
    idle(8);
    chk("stream_count", 32'(rsp_log.size()), 32'd16);
    if (rsp_log.size() == 16) begin
      for (int t = 0; t < 16; t++) begin
        chk("stream_tag", 32'(rsp_log[t].tag), 32'(t));
        chk("stream_gap", 32'(rsp_log[t].due - rsp_log[0].due), 32'(t));
      end
    end

    // Reset while three operations are in flight
    rsp_log.delete();
    for (int t = 0; t < 3; t++) step(1'b1, 2'd0, 32'h3F800000, 32'h3F800000, 4'(t + 4), r);
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    inflight.delete();
    last_a = '0; last_b = '0;
    idle(15);
    chk("post_reset_silent", 32'(rsp_log.size()), 32'd0);
    step(1'b1, 2'd0, 32'h3F800000, 32'h40000000, 4'd7, r);
    chk("post_reset_accept", 32'(r), 32'd1);
    idle(10);
    chk("post_reset_rsp", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() == 1) chk("post_reset_data", rsp_log[0].data, 32'h40400000);

    // Randomized traffic against the due-time model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 2'($urandom % 4),
           r2sp(real'($urandom_range(20, 1))), r2sp(real'($urandom_range(8, 1))),
           4'($urandom % 16), r);
    end
    idle(20);
    chk("drain_empty", 32'(inflight.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_op_sched.md
# fpu_op_sched

Issue scheduler for the shared floating-point unit (pipelined add, sub, mul and div cores that all share one operand pair). It accepts single-precision operation requests over a valid/ready handshake and drives the shared operand bus, at most one issue per clock. It tracks every in-flight operation by its fixed core latency and returns each result, with the requester's tag, on a single response port. A completion-slot reservation register guarantees that two results never land on the response port in the same cycle.

## Interface
- LAT_ADD, 7, add core latency in cycles (operands driven to result valid)
- LAT_SUB, 7, sub core latency
- LAT_MUL, 5, mul core latency
- LAT_DIV, 6, div core latency
- MAX_LAT, 16, reservation depth; every LAT_* must satisfy 1 ≤ LAT_* ≤ MAX_LAT (elaboration-time check)
- TAG_W, 4, requester tag width

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on an edge where req_valid && req_ready
- req_op  in  2  operation: 0=add, 1=sub, 2=mul, 3=div
- req_a, req_b  in  32  IEEE-754 single-precision operands
- req_tag  in  TAG_W  returned unchanged with the result
- fpu_dataa, fpu_datab  out  32  registered operands to all four cores
- fpu_res_add, fpu_res_sub, fpu_res_mul, fpu_res_div  in  32  core outputs
- rsp_valid  out  1  one-cycle pulse per completed operation; no backpressure
- rsp_op  out  2  opcode of the completed operation
- rsp_tag  out  TAG_W  tag of the completed operation
- rsp_data  out  32  result
- busy  out  1  at least one operation in flight

## Operation
- L(op) selects the latency parameter for the opcode.
- Reservation vector `res[MAX_LAT:1]`:
  - Bit k set means a result is due k cycles from now.
  - The vector shifts down by one each cycle.
  - A parallel shift register carries {op, tag} per slot.
- Issue condition (req_ready): `res[L(req_op)] == 0`.
  - req_ready is combinational from req_op and res; it may depend on req_op.
  - req_ready is 0 while rst is high.
- On acceptance:
  - Register req_a and req_b onto fpu_dataa and fpu_datab.
  - Set res[L] and store {op, tag} in slot L.
  - This happens in the same edge as the shift, i.e. it is written post-shift.
- fpu_dataa and fpu_datab hold their last value when nothing is issued. The cores compute on every cycle and their outputs are ignored unless a slot is due.
- When the slot reaching index 0 is set:
  - Capture the selected core output (mux by the stored op) into rsp_data.
  - Drive rsp_op and rsp_tag from the slot.
  - Pulse rsp_valid.
- busy = OR of res.
- Reset:
  - Clears res and the tag/op shift register, so all in-flight work is discarded and produces no response.
  - Reset values: rsp_valid=0, rsp_op=0, rsp_tag=0, rsp_data=0, fpu_dataa=0, fpu_datab=0, busy=0.

## Timing
- Request accepted at edge E0 → operands on fpu_data* during the cycle after E0.
- The core result is valid L cycles later and is registered at edge E0+L+1.
- rsp_valid is high for exactly the one cycle following edge E0+L+1. Request-to-response latency is L+1 edges.
- Throughput: one accept per cycle when the slots do not conflict.
- Same-op requests back-to-back never conflict, so they sustain one per cycle.
- Conflict example: ADD at E0 is due at E0+8. MUL at E2 is also due at E2+6 = E0+8, so req_ready=0 at E2 and the MUL is accepted at E3.
- rst asserted mid-operation: outputs go to their reset values immediately (asynchronously). After deassertion, the first edge may accept a request.

## Configuration
- FPU_SCHED_INORDER_EN defined:
  - Responses return strictly in issue order.
  - The issue condition adds: no res bit at index ≥ L(req_op) is set.
  - A short op therefore stalls behind a longer op already in flight.
- Undefined:
  - Responses may return out of order; only the slot collision rule applies.
  - Requesters must use rsp_tag to match responses.

## Test plan
- Single ADD: a=0x3F800000 (1.0), b=0x40000000 (2.0), tag=3, accepted at E0 → single rsp_valid after edge E0+8 with data=0x40400000, op=0, tag=3; busy falls the cycle after.
- SUB, MUL, DIV each alone:
  - 5.0−2.0 → 0x40400000 after LAT_SUB+1 edges.
  - 6.0×0.5 → 0x40400000 after 6 edges.
  - 1.0/4.0 → 0x3E800000 after 7 edges.
- Slot collision: ADD at E0, MUL presented at E2 → req_ready=0 at E2, MUL accepted at E3; responses appear after E0+8 and E3+6 with no double pulse.
- Reordering, ADD tag=1 at E0 and MUL tag=2 presented at E1:
  - Without the macro: MUL is accepted at E1 and responds first (after E0+7, tag=2), then ADD (after E0+8, tag=1).
  - With FPU_SCHED_INORDER_EN: MUL is accepted at E3 and tag order is 1 then 2.
- Streaming 16 back-to-back MULs with tags 0–15 → 16 consecutive rsp_valid cycles, tags in order, req_ready constantly 1.
- rst pulse while 3 ops are in flight → no rsp_valid ever for those ops; all outputs 0; busy=0; a new ADD after deassertion responds normally.
